// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default constants for the FIFO write-port arbiter.
// The package name is fifo_arb_pkg; every arbiter file imports it.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned N_REQ_D     = 4;
  localparam int unsigned DW_D        = 8;
  localparam int unsigned MAX_BURST_D = 4;
  localparam int unsigned BCW         = 4;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshake plus the FIFO write port, grouped as one bundle.
// master = arbiter side, slave = requesters/FIFO side.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_D,
  parameter int unsigned DW    = DW_D
);
  localparam int unsigned GW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                fifo_full;
  logic                fifo_wr_en;
  logic [DW-1:0]       fifo_data_in;
  logic [GW-1:0]       grant_id;
  logic                busy;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_grant,
// wrapping modulo N_REQ (also correct for non-power-of-2 N_REQ).
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_D
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     any
);
  localparam int unsigned GW = $clog2(N_REQ);

  always_comb begin
    int unsigned idx;
    idx    = 0;
    winner = '0;
    any    = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = 32'(last_grant) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req[GW'(idx)]) begin
        any    = 1'b1;
        winner = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters;
// each grant lasts up to MAX_BURST beats and is followed by one IDLE cycle.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = N_REQ_D,
  parameter int unsigned DW        = DW_D,
  parameter int unsigned MAX_BURST = MAX_BURST_D
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int unsigned GW = $clog2(N_REQ);

  arb_state_e     state_q, state_n;
  logic [GW-1:0]  grant_q, grant_n;
  logic [GW-1:0]  last_q,  last_n;
  logic [BCW-1:0] cnt_q,   cnt_n;
  logic [BCW-1:0] cnt_inc;
  logic [GW-1:0]  pick_id;
  logic           pick_any;
  logic           owner_valid;
  logic           xfer;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .winner     (pick_id),
    .any        (pick_any)
  );

  always_comb begin
    owner_valid = bus.req_valid[grant_q];
    xfer        = (state_q == GRANT) && owner_valid && !bus.fifo_full;
    cnt_inc     = cnt_q + BCW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      last_q  <= last_n;
      cnt_q   <= cnt_n;
    end
  end

  // A full FIFO stalls with everything held; the owner dropping valid releases.
  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_n = GRANT;
          grant_n = pick_id;
          last_n  = pick_id;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (!owner_valid) begin
          state_n = IDLE;
        end else if (xfer) begin
          cnt_n = cnt_inc;
          if (cnt_inc == BCW'(MAX_BURST)) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready    = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_data_in = '0;
    bus.busy         = (state_q == GRANT);
    bus.grant_id     = grant_q;
    if (xfer) begin
      bus.req_ready[grant_q] = 1'b1;
      bus.fifo_wr_en         = 1'b1;
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (xfer && (GW'(i) == grant_q)) bus.fifo_data_in = bus.req_data[i*DW +: DW];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed cycle-by-cycle bench for fifo_wr_arbiter (N_REQ=4, DW=8, MAX_BURST=4).
// Inputs change 1 ns after posedge; outputs are checked on the negedge.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;
  logic [7:0] base [4];
  logic [7:0] bcnt [4];
  bit   auto_inc;

  fifo_wr_arbiter_if #(.N_REQ(4), .DW(8)) bus ();

  fifo_wr_arbiter #(.N_REQ(4), .DW(8), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [3:0] v, input logic f,
                      input bit ck, input logic eb, input logic [1:0] eg,
                      input logic [3:0] er, input logic ew, input logic [7:0] ed);
    rst           = r;
    bus.req_valid = v;
    bus.fifo_full = f;
    for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = base[i] + bcnt[i];
    @(negedge clk);
    if (ck) begin
      chk({tag, "/busy"}, 32'(bus.busy), 32'(eb));
      if (eb) chk({tag, "/gid"}, 32'(bus.grant_id), 32'(eg));
      chk({tag, "/ready"}, 32'(bus.req_ready), 32'(er));
      chk({tag, "/wr_en"}, 32'(bus.fifo_wr_en), 32'(ew));
      chk({tag, "/data"}, 32'(bus.fifo_data_in), 32'(ed));
    end
    if (auto_inc)
      for (int i = 0; i < 4; i++) if (v[i] && bus.req_ready[i]) bcnt[i] = bcnt[i] + 8'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) begin
      base[i] = 8'h00;
      bcnt[i] = 8'h00;
    end
    auto_inc = 1'b0;
    step("rst", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
    step("rst", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      base[i] = 8'(i);
      bcnt[i] = 8'h00;
    end
    auto_inc      = 1'b0;
    bus.req_data  = '0;

    // Reset with every requester valid, then first grant goes to 0.
    step("t1_rst0", 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
    step("t1_rst1", 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
    step("t1_idle", 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
    step("t1_gnt0", 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1, 8'h00);

    // Lone requester 2 with incrementing data 0x20..0x27.
    do_reset();
    base[2]  = 8'h20;
    auto_inc = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c == 0 || c == 5 || c == 10)
        step($sformatf("t2_c%0d", c), 1'b0, (c == 10) ? 4'h0 : 4'h4, 1'b0, 1'b1,
             1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
      else
        step($sformatf("t2_c%0d", c), 1'b0, 4'h4, 1'b0, 1'b1,
             1'b1, 2'd2, 4'h4, 1'b1, 8'h20 + 8'((c < 5) ? c - 1 : c - 2));
    end

    // All four valid, data = id: bursts of 4 rotating 0,1,2,3,0 with idle gaps.
    do_reset();
    for (int i = 0; i < 4; i++) base[i] = 8'(i);
    for (int k = 0; k < 22; k++) begin
      int p;
      int g;
      p = (k - 1) % 5;
      g = ((k - 1) / 5) % 4;
      if (k == 0 || p == 4)
        step($sformatf("t3_c%0d", k), 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
      else
        step($sformatf("t3_c%0d", k), 1'b0, 4'hF, 1'b0, 1'b1,
             1'b1, 2'(g), 4'(1 << g), 1'b1, 8'(g));
    end

    // Owner 1 stalled by fifo_full for 5 cycles after 2 beats.
    do_reset();
    base[1] = 8'h11;
    base[2] = 8'h22;
    step("t4_c0", 1'b0, 4'h6, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
    step("t4_c1", 1'b0, 4'h6, 1'b0, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1, 8'h11);
    step("t4_c2", 1'b0, 4'h6, 1'b0, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1, 8'h11);
    for (int c = 3; c <= 7; c++)
      step($sformatf("t4_full%0d", c), 1'b0, 4'h6, 1'b1, 1'b1, 1'b1, 2'd1, 4'h0, 1'b0, 8'h00);
    step("t4_c8",  1'b0, 4'h6, 1'b0, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1, 8'h11);
    step("t4_c9",  1'b0, 4'h6, 1'b0, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1, 8'h11);
    step("t4_c10", 1'b0, 4'h6, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
    step("t4_c11", 1'b0, 4'h6, 1'b0, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1, 8'h22);

    // Owner 3 drops valid after 1 beat; 0 then gets a full fresh burst.
    do_reset();
    base[3] = 8'h33;
    base[0] = 8'h0A;
    step("t5_c0", 1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
    step("t5_c1", 1'b0, 4'h8, 1'b0, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1, 8'h33);
    step("t5_c2", 1'b0, 4'h1, 1'b0, 1'b1, 1'b1, 2'd3, 4'h0, 1'b0, 8'h00);
    step("t5_c3", 1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
    for (int c = 4; c <= 7; c++)
      step($sformatf("t5_c%0d", c), 1'b0, 4'h1, 1'b0, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1, 8'h0A);
    step("t5_c8", 1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);

    // Reset pulsed while owner 2 is at burst_cnt=2; requester 0 wins afterwards.
    do_reset();
    base[2] = 8'h2C;
    base[0] = 8'h0A;
    step("t6_c0", 1'b0, 4'h4, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
    step("t6_c1", 1'b0, 4'h4, 1'b0, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1, 8'h2C);
    step("t6_c2", 1'b0, 4'h4, 1'b0, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1, 8'h2C);
    step("t6_c3", 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
    rst           = 1'b1;
    bus.req_valid = 4'h5;
    @(negedge clk);
    chk("t6_c4/gid_rst", 32'(bus.grant_id), 32'd0);
    @(posedge clk);
    #1;
    step("t6_c4", 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
    step("t6_c5", 1'b0, 4'h5, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
    step("t6_c6", 1'b0, 4'h5, 1'b0, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1, 8'h0A);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
